// File: rtl/conv_pkg.sv
// conv_pkg: state type and default code parameters shared by the convolutional encoder and decoder.
package conv_pkg;
    typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_state_t;
    localparam int         DEF_K  = 3;
    localparam logic [2:0] DEF_G0 = 3'b111;
    localparam logic [2:0] DEF_G1 = 3'b101;
endpackage

// File: rtl/conv_parity.sv
// conv_parity: {G0,G1} parity of a K-bit tap vector; tap[K-1] is the newest (input) bit.
module conv_parity
    import conv_pkg::*;
#(
    parameter int           K  = DEF_K,
    parameter logic [K-1:0] G0 = K'(DEF_G0),
    parameter logic [K-1:0] G1 = K'(DEF_G1)
) (
    input  logic [K-1:0] tap,
    output logic [1:0]   sym
);
    assign sym = {^(G0 & tap), ^(G1 & tap)};
endmodule

// File: rtl/conv_tail_encoder.sv
// conv_tail_encoder: framed rate-1/2 convolutional encoder that closes every frame with K-1 zero tail bits.
module conv_tail_encoder
    import conv_pkg::*;
#(
    parameter int           K         = DEF_K,
    parameter logic [K-1:0] G0        = K'(DEF_G0),
    parameter logic [K-1:0] G1        = K'(DEF_G1),
    parameter int           FRAME_LEN = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable_i,
    input  logic                           d_in,
    input  logic                           flush_i,
    output logic                           ready_o,
    output logic                           valid_o,
    output logic [1:0]                     d_out,
    output logic                           sof_o,
    output logic                           eof_o,
    output logic [$clog2(FRAME_LEN+1)-1:0] bit_ct_o
);
    localparam int            CW       = $clog2(FRAME_LEN+1);
    localparam int            TW       = $clog2(K);
    localparam logic [CW-1:0] LAST     = CW'(FRAME_LEN);
    localparam logic [TW-1:0] TAIL_END = TW'(K-2);

    enc_state_t    state;
    logic [K-2:0]  sr;
    logic [TW-1:0] tail_ct;
    logic [CW-1:0] bit_nxt;
    logic [1:0]    sym;
    logic          bit_in;
    logic          accept;

    assign ready_o = state != TAIL;
    assign accept  = enable_i && ready_o;
    assign bit_in  = (state == TAIL) ? 1'b0 : d_in;
    assign bit_nxt = bit_ct_o + 1'b1;

    conv_parity #(.K(K), .G0(G0), .G1(G1)) u_parity (
        .tap ({bit_in, sr}),
        .sym (sym)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sr       <= '0;
            tail_ct  <= '0;
            bit_ct_o <= '0;
            valid_o  <= 1'b0;
            d_out    <= '0;
            sof_o    <= 1'b0;
            eof_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
            eof_o   <= 1'b0;
            if (state == TAIL) begin
                valid_o <= 1'b1;
                d_out   <= sym;
                if (tail_ct == TAIL_END) begin
                    state    <= IDLE;
                    eof_o    <= 1'b1;
                    sr       <= '0;
                    tail_ct  <= '0;
                    bit_ct_o <= '0;
                end else begin
                    sr      <= {1'b0, sr[K-2:1]};
                    tail_ct <= tail_ct + 1'b1;
                end
            end else if (accept) begin
                valid_o  <= 1'b1;
                d_out    <= sym;
                sr       <= {d_in, sr[K-2:1]};
                bit_ct_o <= bit_nxt;
                sof_o    <= state == IDLE;
                // a flush arriving with the very first bit of a frame is ignored, as in IDLE
                state    <= (bit_nxt == LAST || (flush_i && state == DATA)) ? TAIL : DATA;
            end else if (flush_i && state == DATA) begin
                state <= TAIL;
            end
        end
    end
endmodule

// File: tb/tb_conv_tail_encoder.sv
// tb_conv_tail_encoder: vector table, hand sequences and a randomized frame-level model check
// across three instances (FRAME_LEN = 4, 256, 1) driven from the same inputs.
module tb_conv_tail_encoder;
    localparam int         K  = 3;
    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;

    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, d = 1'b0, fl = 1'b0;
    logic       rdy [3], vld [3], sof [3], eof [3];
    logic [1:0] dout [3];
    logic [2:0] bct0;
    logic [8:0] bct1;
    logic [0:0] bct2;
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    conv_tail_encoder #(.FRAME_LEN(4)) u0 (
        .clk(clk), .rst(rst), .enable_i(en), .d_in(d), .flush_i(fl), .ready_o(rdy[0]),
        .valid_o(vld[0]), .d_out(dout[0]), .sof_o(sof[0]), .eof_o(eof[0]), .bit_ct_o(bct0));
    conv_tail_encoder #(.FRAME_LEN(256)) u1 (
        .clk(clk), .rst(rst), .enable_i(en), .d_in(d), .flush_i(fl), .ready_o(rdy[1]),
        .valid_o(vld[1]), .d_out(dout[1]), .sof_o(sof[1]), .eof_o(eof[1]), .bit_ct_o(bct1));
    conv_tail_encoder #(.FRAME_LEN(1)) u2 (
        .clk(clk), .rst(rst), .enable_i(en), .d_in(d), .flush_i(fl), .ready_o(rdy[2]),
        .valid_o(vld[2]), .d_out(dout[2]), .sof_o(sof[2]), .eof_o(eof[2]), .bit_ct_o(bct2));

    typedef struct {
        bit rs; int u; bit e, b, f;
        bit rdy, vld; logic [1:0] dout; bit sof, eof; int bct;
    } vec_t;
    vec_t tbl [$];

    function automatic vec_t v(int rs, int u, int e, int b, int f, int r, int vl, int dq, int s, int eo, int bc);
        vec_t x;
        x.rs = rs[0]; x.u = u; x.e = e[0]; x.b = b[0]; x.f = f[0];
        x.rdy = r[0]; x.vld = vl[0]; x.dout = dq[1:0]; x.sof = s[0]; x.eof = eo[0]; x.bct = bc;
        return x;
    endfunction

    function automatic int bct(int u);
        return u == 0 ? int'(bct0) : u == 1 ? int'(bct1) : int'(bct2);
    endfunction

    function automatic int fl_of(int u);
        return u == 0 ? 4 : u == 1 ? 256 : 1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input bit e, input bit b, input bit f);
        en = e; d = b; fl = f;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    // Reference model: per frame, the coded stream is the convolution of the frame's bit
    // sequence (data followed by K-1 zeros) with each generator, bit K-1-j weighting x[p-j].
    bit         fb [3][300];
    int         m_n [3], m_pos [3], m_tl [3];
    logic [1:0] m_dout [3];
    bit         m_vld [3], m_sof [3], m_eof [3];

    function automatic logic [1:0] conv_sym(int u, int p);
        logic [1:0] s = 2'b00;
        for (int j = 0; j < K; j++)
            if (p - j >= 0 && fb[u][p-j]) s ^= {G0[K-1-j], G1[K-1-j]};
        return s;
    endfunction

    function automatic void model_reset();
        for (int u = 0; u < 3; u++) begin
            m_n[u] = 0; m_pos[u] = 0; m_tl[u] = 0; m_dout[u] = 2'b00;
            m_vld[u] = 0; m_sof[u] = 0; m_eof[u] = 0;
        end
    endfunction

    function automatic void model_step(int u, bit e, bit b, bit f);
        m_vld[u] = 0; m_sof[u] = 0; m_eof[u] = 0;
        if (m_tl[u] > 0) begin
            fb[u][m_pos[u]] = 1'b0;
            m_dout[u] = conv_sym(u, m_pos[u]);
            m_pos[u]++; m_vld[u] = 1; m_tl[u]--;
            if (m_tl[u] == 0) begin
                m_eof[u] = 1; m_n[u] = 0; m_pos[u] = 0;
            end
        end else if (e) begin
            fb[u][m_pos[u]] = b;
            m_dout[u] = conv_sym(u, m_pos[u]);
            m_pos[u]++; m_vld[u] = 1; m_sof[u] = m_n[u] == 0;
            if ((m_n[u] > 0 && f) || m_n[u] + 1 == fl_of(u)) m_tl[u] = K - 1;
            m_n[u]++;
        end else if (f && m_n[u] > 0) begin
            m_tl[u] = K - 1;
        end
    endfunction

    task automatic check_model(input int c);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("r%0d_u%0d_vld", c, u), vld[u], m_vld[u]);
            chk($sformatf("r%0d_u%0d_dout", c, u), dout[u], m_dout[u]);
            chk($sformatf("r%0d_u%0d_sof", c, u), sof[u], m_sof[u]);
            chk($sformatf("r%0d_u%0d_eof", c, u), eof[u], m_eof[u]);
            chk($sformatf("r%0d_u%0d_bct", c, u), bct(u), m_n[u]);
        end
    endtask

    initial begin
        // u0 (FRAME_LEN=4): continuous 1,0,1,1 then a new frame right after the tail
        tbl.push_back(v(1,0,1,1,0, 1,1,3,1,0,1));
        tbl.push_back(v(0,0,1,0,0, 1,1,2,0,0,2));
        tbl.push_back(v(0,0,1,1,0, 1,1,0,0,0,3));
        tbl.push_back(v(0,0,1,1,0, 1,1,1,0,0,4));
        tbl.push_back(v(0,0,1,1,0, 0,1,1,0,0,4));
        tbl.push_back(v(0,0,1,1,0, 0,1,3,0,1,0));
        tbl.push_back(v(0,0,1,1,0, 1,1,3,1,0,1));
        // u0: same data with enable gaps 1,0,0,1,1,0,1
        tbl.push_back(v(1,0,1,1,0, 1,1,3,1,0,1));
        tbl.push_back(v(0,0,0,0,0, 1,0,3,0,0,1));
        tbl.push_back(v(0,0,0,1,0, 1,0,3,0,0,1));
        tbl.push_back(v(0,0,1,0,0, 1,1,2,0,0,2));
        tbl.push_back(v(0,0,1,1,0, 1,1,0,0,0,3));
        tbl.push_back(v(0,0,0,0,0, 1,0,0,0,0,3));
        tbl.push_back(v(0,0,1,1,0, 1,1,1,0,0,4));
        tbl.push_back(v(0,0,0,0,0, 0,1,1,0,0,4));
        tbl.push_back(v(0,0,0,0,0, 0,1,3,0,1,0));
        tbl.push_back(v(0,0,0,0,0, 1,0,3,0,0,0));
        // u1 (FRAME_LEN=256): flush with the 3rd bit; tail ignores inputs; next frame from sr=0
        tbl.push_back(v(1,1,1,1,0, 1,1,3,1,0,1));
        tbl.push_back(v(0,1,1,1,0, 1,1,1,0,0,2));
        tbl.push_back(v(0,1,1,1,1, 1,1,2,0,0,3));
        tbl.push_back(v(0,1,1,0,1, 0,1,1,0,0,3));
        tbl.push_back(v(0,1,0,0,0, 0,1,3,0,1,0));
        tbl.push_back(v(0,1,1,1,0, 1,1,3,1,0,1));
        // u1: flush with the first bit is ignored; later flush without accept starts the tail
        tbl.push_back(v(1,1,1,1,1, 1,1,3,1,0,1));
        tbl.push_back(v(0,1,1,0,0, 1,1,2,0,0,2));
        tbl.push_back(v(0,1,0,0,1, 1,0,2,0,0,2));
        tbl.push_back(v(0,1,0,0,0, 0,1,3,0,0,2));
        tbl.push_back(v(0,1,0,0,0, 0,1,0,0,1,0));
        // u2 (FRAME_LEN=1): back-to-back single-bit frames
        tbl.push_back(v(1,2,1,1,0, 1,1,3,1,0,1));
        tbl.push_back(v(0,2,1,1,0, 0,1,2,0,0,1));
        tbl.push_back(v(0,2,1,1,0, 0,1,3,0,1,0));
        tbl.push_back(v(0,2,1,1,0, 1,1,3,1,0,1));
        tbl.push_back(v(0,2,1,1,0, 0,1,2,0,0,1));
        tbl.push_back(v(0,2,1,1,0, 0,1,3,0,1,0));

        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst_u%0d_rdy", u), rdy[u], 1);
            chk($sformatf("rst_u%0d_vld", u), vld[u], 0);
            chk($sformatf("rst_u%0d_dout", u), dout[u], 0);
            chk($sformatf("rst_u%0d_sof_eof", u), {sof[u], eof[u]}, 0);
            chk($sformatf("rst_u%0d_bct", u), bct(u), 0);
        end
        rst = 1'b1;

        foreach (tbl[i]) begin
            int u;
            u = tbl[i].u;
            if (tbl[i].rs) pulse_reset();
            chk($sformatf("v%0d_rdy", i), rdy[u], tbl[i].rdy);
            tick(tbl[i].e, tbl[i].b, tbl[i].f);
            chk($sformatf("v%0d_vld", i), vld[u], tbl[i].vld);
            chk($sformatf("v%0d_dout", i), dout[u], tbl[i].dout);
            chk($sformatf("v%0d_sof", i), sof[u], tbl[i].sof);
            chk($sformatf("v%0d_eof", i), eof[u], tbl[i].eof);
            chk($sformatf("v%0d_bct", i), bct(u), tbl[i].bct);
        end

        // reset asserted during the first tail cycle of u0 takes effect without a clock
        pulse_reset();
        tick(1, 1, 0); tick(1, 0, 0); tick(1, 1, 0); tick(1, 1, 0);
        chk("midtail_rdy_before", rdy[0], 0);
        rst = 1'b0;
        #1;
        chk("midtail_vld", vld[0], 0);
        chk("midtail_dout", dout[0], 0);
        chk("midtail_sof_eof", {sof[0], eof[0]}, 0);
        chk("midtail_bct", bct(0), 0);
        chk("midtail_rdy", rdy[0], 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(1, 1, 0);
        chk("after_rst_dout", dout[0], 3);
        chk("after_rst_sof", sof[0], 1);
        chk("after_rst_bct", bct(0), 1);

        // randomized traffic on all three instances against the frame-level model
        pulse_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit e, b, f;
            e = $urandom_range(0, 9) < 7;
            b = 1'($urandom);
            f = $urandom_range(0, 19) == 0;
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
                model_reset();
                check_model(c);
            end
            for (int u = 0; u < 3; u++)
                chk($sformatf("r%0d_u%0d_rdy", c, u), rdy[u], m_tl[u] == 0);
            tick(e, b, f);
            for (int u = 0; u < 3; u++) model_step(u, e, b, f);
            check_model(c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/conv_tail_encoder.md
# conv_tail_encoder

Framed rate-1/2 convolutional encoder, the transmit end of the Viterbi link. It accepts one information bit per handshake, emits one 2-bit coded symbol per bit, and terminates each frame with K-1 zero tail bits so the decoder ends every frame in state 0. It sits ahead of the channel/error-injection stage and drives the decoder's enable/symbol inputs.

## Interface
- K, 3, constraint length (3..9)
- G0, 'b111, generator for d_out[1]; bit K-1 taps d_in
- G1, 'b101, generator for d_out[0]; bit K-1 taps d_in
- FRAME_LEN, 256, maximum data bits per frame (≥1)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- enable_i  in  1  d_in is valid this cycle
- d_in  in  1  information bit
- flush_i  in  1  end the current frame early; sampled in DATA only
- ready_o  out  1  encoder accepts a bit this cycle
- valid_o  out  1  d_out holds a new symbol
- d_out  out  2  coded symbol {G0 parity, G1 parity}
- sof_o  out  1  first symbol of a frame
- eof_o  out  1  last tail symbol of a frame
- bit_ct_o  out  $clog2(FRAME_LEN+1)  data bits accepted in the current frame

## Operation
- Shift register sr[K-2:0]: sr[K-2] is the newest bit, sr[0] the oldest. Tap vector is {d_in, sr}. d_out[1] = ^(G0 & tap), d_out[0] = ^(G1 & tap). On each coded bit, sr <= {bit, sr[K-2:1]}.
- Accept = enable_i && ready_o. ready_o = (state != TAIL). It is decoded from state, so it reads 1 during and after reset.
- States:
  - IDLE: accept → DATA, sof_o=1 with that symbol, bit_ct=1.
  - DATA: each accept encodes d_in and increments bit_ct. Cycles without enable_i produce valid_o=0 and hold all state.
  - DATA → TAIL when the accepted bit makes bit_ct==FRAME_LEN, or when flush_i=1. If flush_i and an accept occur in the same cycle, that bit is encoded first and is the last data bit. flush_i without an accept ends the frame with no extra data symbol.
  - TAIL: emits K-1 zero-input symbols on consecutive cycles (valid_o=1), ignores enable_i, d_in and flush_i. eof_o=1 on the last tail symbol. Then → IDLE with sr=0 and bit_ct=0.
- K=1 is not supported (minimum K is 3).
- Cases where the frame ends on the FRAME_LEN-th accepted bit:
  - FRAME_LEN=1: that first bit is both sof and the last data bit, so the state goes IDLE → TAIL directly.
  - flush_i in the same cycle as that bit has no additional effect.
- flush_i in IDLE is ignored.
- bit_ct_o never exceeds FRAME_LEN and wraps to 0 only on return to IDLE.

## Timing
- All outputs except ready_o are registered. A symbol appears on the cycle after its accept or tail cycle. valid_o, sof_o and eof_o are single-cycle pulses aligned with d_out.
- Reset (asynchronous, any state including mid-TAIL):
  - state=IDLE, sr=0, bit_ct_o=0
  - valid_o=0, d_out=2'b00, sof_o=0, eof_o=0
  - Partial frames are discarded with no tail.
- d_out holds its last value when valid_o=0.
- Minimum frame duration is N+K-1 symbol cycles. A new frame can be accepted on the first cycle after the last tail cycle. With continuous enable_i, the only gap is the K-1 cycles where ready_o=0.

## Structure
- Package conv_pkg: typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_state_t; default K/G0/G1 localparams, shared with the decoder.
- One sub-module, conv_parity: combinational {G0,G1} parity of the K-bit tap vector. It is reusable by the decoder's branch-metric unit.
- Top level holds the FSM, bit/tail counters and sr.

## Test plan
- K=3, FRAME_LEN=4, continuous enable_i, d_in=1,0,1,1:
  - d_out = 11,10,00,01 then tail 01,11.
  - sof_o on the 1st symbol, eof_o on the 6th.
  - ready_o=0 for exactly 2 cycles.
- Same data with enable_i gapped (1,0,0,1,1,0,1): identical symbol sequence with valid_o=0 in the gaps, and bit_ct_o steps 1..4.
- FRAME_LEN=256, flush_i together with the 3rd accepted bit (1,1,1): 11,01,10, then tail 01,11; eof_o on the 5th symbol; next frame starts with sr=0.
- Reset asserted during the first tail cycle: outputs and bit_ct_o go to 0 immediately. The next frame with d_in=1 yields 11 with sof_o=1.
- FRAME_LEN=1, back-to-back frames of single bit 1: per frame 11,10,11. ready_o is low for 2 cycles between frames; there are no lost or duplicated symbols.
